load_store_unit: RTL and testbench

Memory-access-stage load/store unit sitting between the MIPS pipeline MEM stage and the word-addressed 1K×32 data RAM. It accepts one load or store request at a time and drives the RAM's word interface. It performs byte and halfword extraction with sign or zero extension on loads, and read-modify-write merging for sub-word stores, because the RAM writes whole words only. It flags misaligned accesses without touching memory and signals completion with a one-cycle `done` pulse.

---
 rtl/load_store_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   MEM-stage load/store unit in front of a word-addressed 1Kx32 data RAM.
//   It accepts one request at a time and handles one access per request:
//     - loads: byte/half/word, with sign or zero extension;
//     - stores: word stores directly, and byte/half stores by
//       read-modify-write, because the RAM only writes whole words.
//   Misaligned accesses and the reserved size complete with err=1 and
//   never touch the RAM.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req/ready       request strobe, accepted only while ready=1
//   store, size     operation: store (1) or load (0); size 00=B, 01=H, 10=W
//   sign_ext        load extension mode
//   addr, wdata     byte address and right-aligned store data
//   done/err/rdata  completion pulse, error flag, load result (held)
//   mem_*           RAM word interface (mem_dout is combinational)
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                store_q;
    logic                sign_ext_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   word_q;
    logic [DATA_W-1:0]   rdata_r;
    logic                err_q;
    logic                bad_s;
    logic                accept_s;

    // Pick the addressed lane(s) out of a RAM word and extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lo,
                                                 input logic [1:0]  sz,
                                                 input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay right-aligned store data onto the old word at the addressed lane(s).
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wd,
                                                input logic [1:0]  lo,
                                                input logic [1:0]  sz);
        logic [31:0] r;
        r = word;
        case (sz)
            2'b00: begin
                case (lo)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    2'd3:    r[31:24] = wd[7:0];
                    default: r = word;
                endcase
            end
            2'b01: begin
                if (lo[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Error conditions on the incoming request: reserved size or misalignment.
    always_comb begin
        bad_s = 1'b0;
        case (size)
            2'b00:   bad_s = 1'b0;
            2'b01:   bad_s = addr[0];
            2'b10:   bad_s = (addr[1:0] != 2'b00);
            default: bad_s = 1'b1;
        endcase
    end

    assign accept_s = (state_r == IDLE) && req;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; sub-word stores take the RD detour for the merge.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!req) begin
                    state_next_s = IDLE;
                end else if (bad_s) begin
                    state_next_s = RESP;
                end else if (store && (size == 2'b10)) begin
                    state_next_s = WR;
                end else begin
                    state_next_s = RD;
                end
            end
            RD: begin
                if (store_q) begin
                    state_next_s = WR;
                end else begin
                    state_next_s = RESP;
                end
            end
            WR:      state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Request latches, RAM word capture and load result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= {ADDR_W{1'b0}};
            size_q     <= 2'b00;
            store_q    <= 1'b0;
            sign_ext_q <= 1'b0;
            wdata_q    <= {DATA_W{1'b0}};
            word_q     <= {DATA_W{1'b0}};
            rdata_r    <= {DATA_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            if (accept_s) begin
                addr_q     <= addr;
                size_q     <= size;
                store_q    <= store;
                sign_ext_q <= sign_ext;
                wdata_q    <= wdata;
                err_q      <= bad_s;
            end
            if (state_r == RD) begin
                word_q <= mem_dout;
                if (!store_q) begin
                    rdata_r <= load_extract(mem_dout, addr_q[1:0], size_q, sign_ext_q);
                end
            end
        end
    end

    // Output decode from the registered state; mem_we is gated so reset never writes.
    always_comb begin
        ready    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = {ADDR_W{1'b0}};
        mem_din  = {DATA_W{1'b0}};
        case (state_r)
            IDLE: ready = 1'b1;
            RD: begin
                mem_re   = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
            end
            WR: begin
                mem_we   = !rst;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                if (size_q == 2'b10) begin
                    mem_din = wdata_q;
                end else begin
                    mem_din = store_merge(word_q, wdata_q, addr_q[1:0], size_q);
                end
            end
            RESP: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ready = 1'b0;
        endcase
    end

    assign rdata = rdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 1Kx32 RAM.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        store;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_dout;

    logic [31:0] ram [0:1023] = '{default: 32'h0};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] last_rdata = 32'h0;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req(req), .store(store), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready),
        .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: combinational read, write on rising edge
    assign mem_dout = mem_re ? ram[mem_addr[11:2]] : 32'h0;
    always @(posedge clk) if (mem_we) ram[mem_addr[11:2]] <= mem_din;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse
    always @(negedge clk) begin
        if (!rst) begin
            check("re_we_exclusive", {31'h0, mem_re & mem_we}, 32'h0);
            if (sb_q.size() != 0 && sb_q[0].err)
                check("err_no_mem", {30'h0, mem_re, mem_we}, 32'h0);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'h1, 32'h0);
                end else begin
                    exp_t x;
                    x = sb_q.pop_front();
                    check({x.name, "_err"}, {31'h0, err}, {31'h0, x.err});
                    check({x.name, "_rdata"}, rdata, x.rdata);
                    check({x.name, "_latency"}, cyc, x.cyc);
                    check({x.name, "_ready_low"}, {31'h0, ready}, 32'h0);
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        if (!ready) check("ready_timeout", 32'h0, 32'h1);
    endtask

    task automatic issue(input string nm, input logic st, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic e, input int lat);
        exp_t x;
        int   t;
        wait_ready();
        req = 1'b1; store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
        if (!st && !e) last_rdata = exp_rd;
        x.rdata = last_rdata; x.err = e; x.cyc = cyc + lat; x.name = nm;
        sb_q.push_back(x);
        @(posedge clk); #1;
        req = 1'b0;
        t = 0;
        while (sb_q.size() != 0 && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        if (sb_q.size() != 0) begin
            check({nm, "_done_timeout"}, 32'h0, 32'h1);
            sb_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_ready"}, {31'h0, ready}, 32'h1);
        check({nm, "_done"}, {31'h0, done}, 32'h0);
        check({nm, "_err"}, {31'h0, err}, 32'h0);
        check({nm, "_rdata"}, rdata, 32'h0);
        check({nm, "_mem_ctl"}, {30'h0, mem_re, mem_we}, 32'h0);
        check({nm, "_mem_addr"}, mem_addr, 32'h0);
        check({nm, "_mem_din"}, mem_din, 32'h0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; store = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("reset");
        @(negedge clk); #1;

        // word store / load
        issue("sw_100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 32'h0, 1'b0, 2);
        issue("lw_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11223344, 1'b0, 2);
        // sub-word merges
        issue("sb_102", 1'b1, 2'b00, 1'b0, 32'h102, 32'hFFFFFFAB, 32'h0, 1'b0, 3);
        issue("lw_sb", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11AB3344, 1'b0, 2);
        issue("sh_100", 1'b1, 2'b01, 1'b0, 32'h100, 32'h1234BEEF, 32'h0, 1'b0, 3);
        issue("lw_sh", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11ABBEEF, 1'b0, 2);
        // extension
        issue("sw_200", 1'b1, 2'b10, 1'b0, 32'h200, 32'h80F07F00, 32'h0, 1'b0, 2);
        issue("lb_202_s", 1'b0, 2'b00, 1'b1, 32'h202, 32'h0, 32'hFFFFFFF0, 1'b0, 2);
        issue("lb_202_u", 1'b0, 2'b00, 1'b0, 32'h202, 32'h0, 32'h000000F0, 1'b0, 2);
        issue("lh_202_s", 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'hFFFF80F0, 1'b0, 2);
        issue("lb_201_s", 1'b0, 2'b00, 1'b1, 32'h201, 32'h0, 32'h0000007F, 1'b0, 2);
        issue("lh_200_u", 1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 32'h00007F00, 1'b0, 2);
        issue("lb_203_u", 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h00000080, 1'b0, 2);
        // errors: rdata must stay at the last load value
        issue("lh_101", 1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 32'h0, 1'b1, 1);
        issue("lw_102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1);
        issue("sz11_st", 1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        issue("sh_103", 1'b1, 2'b01, 1'b0, 32'h103, 32'h00005555, 32'h0, 1'b1, 1);
        issue("lw_after_err", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11ABBEEF, 1'b0, 2);

        // busy: req held high through a byte store
        wait_ready();
        req = 1'b1; store = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h301; wdata = 32'h000000CD;
        begin
            exp_t x;
            x.rdata = last_rdata; x.err = 1'b0; x.cyc = cyc + 3; x.name = "sb_busy";
            sb_q.push_back(x);
        end
        @(posedge clk); #1;
        size = 2'b10; addr = 32'h304; wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        req = 1'b0;
        check("busy_queue_drained", sb_q.size(), 32'h0);
        @(negedge clk); #1;
        issue("lw_300", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0000CD00, 1'b0, 2);
        issue("lw_304", 1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 32'h00000000, 1'b0, 2);

        // reset in RD of a read-modify-write
        wait_ready();
        req = 1'b1; store = 1'b1; size = 2'b00; addr = 32'h102; wdata = 32'h00000055;
        @(posedge clk); #1;
        req = 1'b0;
        check("rst_rd_in_rd", {31'h0, mem_re}, 32'h1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        last_rdata = 32'h0;
        check_reset_outputs("rst_rd");
        check("rst_rd_ram", ram[10'h040], 32'h11ABBEEF);
        @(negedge clk); #1;

        // reset in WR of a read-modify-write
        req = 1'b1; store = 1'b1; size = 2'b00; addr = 32'h102; wdata = 32'h00000055;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("rst_wr_we", {31'h0, mem_we}, 32'h1);
        check("rst_wr_din", mem_din, 32'h1155BEEF);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_reset_outputs("rst_wr");
        check("rst_wr_ram", ram[10'h040], 32'h11ABBEEF);
        @(negedge clk); #1;
        issue("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11ABBEEF, 1'b0, 2);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
